// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Receive-side frame decoder for the UART link. It drains the UART core's
// RX FIFO, hunts for the sync byte, and collects a 4-byte payload plus an
// XOR checksum. On a good frame it publishes the remote player's position
// and flags as registered outputs.
//
// Frame on the wire: SYNC, B0={flags,x[11:8]}, B1=x[7:0],
// B2={ignored,y[11:8]}, B3=y[7:0], CHK=B0^B1^B2^B3.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   rx_empty     RX FIFO empty flag
//   r_data[7:0]  RX FIFO head byte, valid while rx_empty=0
//   rd_uart      FIFO pop strobe (combinational, = !rx_empty)
//   pos_x[11:0]  remote X position
//   pos_y[11:0]  remote Y position
//   flags[3:0]   remote status flags
//   frame_valid  one-cycle pulse when a good frame is published
//   frame_err    one-cycle pulse on checksum mismatch or inter-byte timeout
//   err_cnt[7:0] saturating count of frame_err pulses
//                (present only when UART_FRAME_ERRCNT_EN is defined)
//
// Optional build macro: UART_FRAME_ERRCNT_EN adds the err_cnt output.

module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic [3:0]  flags,
  output logic        frame_valid,
`ifdef UART_FRAME_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  // Counter value on the cycle before it would reach TIMEOUT_CYC.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      sh_flags_q, sh_flags_d;
  logic [11:0]     sh_x_q, sh_x_d;
  logic [11:0]     sh_y_q, sh_y_d;
  logic [11:0]     pos_x_q, pos_x_d;
  logic [11:0]     pos_y_q, pos_y_d;
  logic [3:0]      flags_q, flags_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            consume;

  // The block never stalls the FIFO, so every non-empty cycle pops a byte,
  // even while in reset (those bytes are simply thrown away).
  assign rd_uart = !rx_empty;
  assign consume = !rx_empty;

  // Next-state logic: sync hunt, payload capture into shadow registers,
  // checksum verdict, and the inter-byte timeout. A byte arriving on the
  // cycle the counter would expire takes priority over the timeout.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    to_cnt_d      = to_cnt_q;
    sh_flags_d    = sh_flags_q;
    sh_x_d        = sh_x_q;
    sh_y_d        = sh_y_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    flags_d       = flags_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (consume && (r_data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = 2'd0;
          chk_d   = 8'h00;
        end
      end

      PAYLOAD, CHECK: begin
        if (consume) begin
          to_cnt_d = '0;
          if (state_q == PAYLOAD) begin
            chk_d = chk_q ^ r_data;
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0: begin
                sh_flags_d     = r_data[7:4];
                sh_x_d[11:8]   = r_data[3:0];
              end
              2'd1: sh_x_d[7:0]  = r_data;
              2'd2: sh_y_d[11:8] = r_data[3:0];
              default: begin
                sh_y_d[7:0] = r_data;
                state_d     = CHECK;
              end
            endcase
          end else begin
            if (r_data == chk_q) begin
              pos_x_d       = sh_x_q;
              pos_y_d       = sh_y_q;
              flags_d       = sh_flags_q;
              frame_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef UART_FRAME_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; each frame_err pulse counts once.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      chk_q         <= 8'h00;
      to_cnt_q      <= '0;
      sh_flags_q    <= 4'h0;
      sh_x_q        <= 12'h000;
      sh_y_q        <= 12'h000;
      pos_x_q       <= 12'h000;
      pos_y_q       <= 12'h000;
      flags_q       <= 4'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      to_cnt_q      <= to_cnt_d;
      sh_flags_q    <= sh_flags_d;
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      flags_q       <= flags_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign flags       = flags_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
// Self-checking bench for uart_frame_rx. A frame-level model (a byte queue
// per frame, an idle-cycle count) predicts outputs every cycle, directed
// sequences pin known frames to literal values, and a randomized phase
// mixes good/bad frames, garbage, gaps, timeouts and resets.
// A small TIMEOUT_CYC keeps timeout scenarios short.

`timescale 1ns/1ps

module tb_uart_frame_rx;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic [3:0]  flags;
  logic        frame_valid;
  logic        frame_err;
`ifdef UART_FRAME_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  uart_frame_rx #(
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TO),
    .TO_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .flags      (flags),
    .frame_valid(frame_valid),
`ifdef UART_FRAME_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .frame_err  (frame_err)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: collects bytes from sync onward and judges the
  // frame once six bytes are in hand; idle cycles inside a frame count
  // toward the timeout.
  logic [7:0]  frame_q[$];
  int          idle_cnt;
  logic [11:0] m_x, m_y;
  logic [3:0]  m_f;
  logic        m_v, m_e;
  int          m_cnt;
  logic [7:0]  m_sum;

  always @(posedge clk) begin
    m_v = 1'b0;
    m_e = 1'b0;
    if (rst) begin
      frame_q.delete();
      idle_cnt = 0;
      m_x = 12'h000;
      m_y = 12'h000;
      m_f = 4'h0;
      m_cnt = 0;
    end else if (!rx_empty) begin
      idle_cnt = 0;
      if (frame_q.size() != 0 || r_data == SYNC) frame_q.push_back(r_data);
      if (frame_q.size() == 6) begin
        m_sum = frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4];
        if (m_sum == frame_q[5]) begin
          m_f = frame_q[1][7:4];
          m_x = {frame_q[1][3:0], frame_q[2]};
          m_y = {frame_q[3][3:0], frame_q[4]};
          m_v = 1'b1;
        end else begin
          m_e = 1'b1;
        end
        frame_q.delete();
      end
    end else if (frame_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        m_e = 1'b1;
        frame_q.delete();
        idle_cnt = 0;
      end
    end
    if (m_e && m_cnt != 255) m_cnt++;
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("rd_uart", {31'd0, rd_uart}, {31'd0, !rx_empty});
      cmp("pos_x", {20'd0, pos_x}, {20'd0, m_x});
      cmp("pos_y", {20'd0, pos_y}, {20'd0, m_y});
      cmp("flags", {28'd0, flags}, {28'd0, m_f});
      cmp("frame_valid", {31'd0, frame_valid}, {31'd0, m_v});
      cmp("frame_err", {31'd0, frame_err}, {31'd0, m_e});
`ifdef UART_FRAME_ERRCNT_EN
      cmp("err_cnt", {24'd0, err_cnt}, m_cnt);
`endif
    end
  end

  // Drive one cycle of FIFO state; returns just after the following negedge,
  // so the edge that consumes this byte has not happened yet.
  task automatic applyStimulus(input logic emp, input logic [7:0] d);
    @(negedge clk);
    #1;
    rx_empty = emp;
    r_data   = d;
  endtask

  task automatic sendBytes(input logic [7:0] b[]);
    foreach (b[i]) applyStimulus(1'b0, b[i]);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'($urandom));
  endtask

  // Literal expectations for directed scenarios.
  task automatic checkOutput(input string name, input logic [11:0] x, input logic [11:0] y,
                             input logic [3:0] f, input logic v, input logic e);
    cmp({name, ".pos_x"}, {20'd0, pos_x}, {20'd0, x});
    cmp({name, ".pos_y"}, {20'd0, pos_y}, {20'd0, y});
    cmp({name, ".flags"}, {28'd0, flags}, {28'd0, f});
    cmp({name, ".valid"}, {31'd0, frame_valid}, {31'd0, v});
    cmp({name, ".err"}, {31'd0, frame_err}, {31'd0, e});
  endtask

  // Reset for a few cycles while the FIFO keeps delivering bytes that must
  // be discarded.
  task automatic doReset(input int cycles);
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, (i == 0) ? SYNC : 8'($urandom));
    @(negedge clk);
    #1;
    rst      = 1'b0;
    rx_empty = 1'b1;
  endtask

  // Random frame: random fields, random B2 high nibble, sometimes a bad CHK,
  // random inter-byte gaps including just-under and over the timeout.
  task automatic randomFrame();
    logic [7:0] b[6];
    int r, gap;
    b[0] = SYNC;
    b[1] = 8'($urandom);
    b[2] = 8'($urandom);
    b[3] = 8'($urandom);
    b[4] = 8'($urandom);
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    if ($urandom_range(0, 4) == 0) b[5] = b[5] ^ 8'(1 << $urandom_range(0, 7));
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) gap = 0;
      else if (r < 90) gap = $urandom_range(1, 3);
      else if (r < 96) gap = TO - 1;
      else gap = TO + $urandom_range(0, 3);
      if (i == 0) gap = $urandom_range(0, 2);
      idleCycles(gap);
      applyStimulus(1'b0, b[i]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_en = 1'b1;
    applyStimulus(1'b0, SYNC);
    applyStimulus(1'b1, 8'h00);
    rst = 1'b0;
    checkOutput("reset", 12'h000, 12'h000, 4'h0, 1'b0, 1'b0);

    // Basic frame, then confirm the pulse lasts a single cycle.
    sendBytes('{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h70});
    idleCycles(1);
    checkOutput("basic", 12'h123, 12'h456, 4'h0, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("basic_pulse", 12'h123, 12'h456, 4'h0, 1'b0, 1'b0);

    sendBytes('{8'hA5, 8'h31, 8'h23, 8'h04, 8'h56, 8'h40});
    idleCycles(1);
    checkOutput("flags", 12'h123, 12'h456, 4'h3, 1'b1, 1'b0);

    // Bad checksum keeps the previous outputs.
    sendBytes('{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h71});
    idleCycles(1);
    checkOutput("bad_chk", 12'h123, 12'h456, 4'h3, 1'b0, 1'b1);

    sendBytes('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h70});
    idleCycles(1);
    checkOutput("garbage", 12'h123, 12'h456, 4'h0, 1'b1, 1'b0);

    // Timeout fires on exactly the TO-th idle cycle inside a frame.
    sendBytes('{8'hA5, 8'h31, 8'h23});
    idleCycles(TO);
    checkOutput("timeout_early", 12'h123, 12'h456, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("timeout", 12'h123, 12'h456, 4'h0, 1'b0, 1'b1);
    sendBytes('{8'hA5, 8'h31, 8'h23, 8'h04, 8'h56, 8'h40});
    idleCycles(1);
    checkOutput("after_timeout", 12'h123, 12'h456, 4'h3, 1'b1, 1'b0);

    // A byte arriving on the last allowed cycle keeps the frame alive.
    sendBytes('{8'hA5, 8'h12, 8'h34});
    idleCycles(TO - 1);
    sendBytes('{8'h05, 8'h67, 8'h44});
    idleCycles(1);
    checkOutput("byte_wins", 12'h234, 12'h567, 4'h1, 1'b1, 1'b0);

    // Back-to-back frames with no idle cycle in between.
    sendBytes('{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h70, 8'hA5});
    checkOutput("b2b_first", 12'h123, 12'h456, 4'h0, 1'b1, 1'b0);
    sendBytes('{8'h12, 8'h34, 8'h05, 8'h67, 8'h44});
    idleCycles(1);
    checkOutput("b2b_second", 12'h234, 12'h567, 4'h1, 1'b1, 1'b0);

    // Reset mid-frame drops the partial frame and clears the outputs.
    sendBytes('{8'hA5, 8'h01});
    doReset(2);
    checkOutput("mid_reset", 12'h000, 12'h000, 4'h0, 1'b0, 1'b0);
    sendBytes('{8'h23, 8'h04, 8'h56, 8'h70, 8'hA5, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h00});
    idleCycles(1);
    checkOutput("post_reset", 12'hFFF, 12'hFFF, 4'h0, 1'b1, 1'b0);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 150; n++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) applyStimulus(1'b0, 8'($urandom));
      if ($urandom_range(0, 29) == 0) doReset($urandom_range(1, 3));
      randomFrame();
    end
    idleCycles(TO + 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
